// File: rtl/risc_pkg.sv
// Shared definitions for the RISC front end: data width, the NOP encoding
// (addi x0, x0, 0) and the instruction-fetch FSM state type.
package risc_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4,
    S_FAULT = 3'd5
  } ifetch_state_t;

endpackage

// File: rtl/risc_ifetch_tmr.sv
// Response-wait timer for the instruction fetch unit.
// It counts up while enabled and saturates at TIMEOUT-1, so it never wraps.
// expired_o is high while the count sits at TIMEOUT-1.
// With TIMEOUT=1 the count is pinned at zero, so expired_o is high at once.
module risc_ifetch_tmr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear wins, otherwise increment until the last value.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register, synchronously reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LAST);

endmodule

// File: rtl/risc_ifetch.sv
// Instruction fetch unit.
// It issues one word request per fetch and holds the returned instruction
// until decode accepts it. On acceptance, pc_advance pulses for one cycle.
//
// Handshakes:
// - Memory side: imem_req stays high in REQ until the cycle imem_gnt is
//   seen.
// - Memory response: it arrives as a single imem_rvalid pulse.
// - Decode side: instr_valid/instr_ready follows strict valid/ready rules.
//   While valid is high, data is stable. Transfer happens on the edge
//   where both are high.
//
// A flush abandons the current fetch. A granted but unanswered request is
// drained so that its late response cannot be mistaken for a new one.
//
// Optional build macro IFETCH_MISALIGN_CHK_EN:
// - Defined: a misaligned pc_addr moves straight to FAULT.
// - Undefined: the low address bits are simply masked.
module risc_ifetch
  import risc_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int XLEN    = risc_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  input  logic [XLEN-1:0] pc_addr,
  input  logic            flush,
  output logic            pc_advance,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_fault,
  output ifetch_state_t   dbg_state
);

  ifetch_state_t   state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] out_q, out_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            adv_q, adv_d;
  logic            tmr_clr;
  logic            tmr_en;
  logic            tmr_expired;

  risc_ifetch_tmr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmr (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  // Next-state logic and datapath updates for the fetch FSM.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    out_d   = out_q;
    pc_d    = pc_q;
    adv_d   = 1'b0;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (fetch_en && !flush) begin
`ifdef IFETCH_MISALIGN_CHK_EN
          if (pc_addr[1:0] != 2'b00) begin
            state_d = S_FAULT;
            pc_d    = pc_addr;
          end else begin
            state_d = S_REQ;
            addr_d  = pc_addr;
          end
`else
          state_d = S_REQ;
          addr_d  = pc_addr & ~XLEN'(3);
`endif
        end
      end
      S_REQ: begin
        if (imem_gnt) begin
          // Once granted, the response must be waited for even when
          // flushed.
          tmr_clr = 1'b1;
          state_d = flush ? S_DRAIN : S_WAIT;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        tmr_en = 1'b1;
        if (imem_rvalid) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            out_d   = imem_rdata;
            pc_d    = addr_q;
            state_d = S_HOLD;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end else if (tmr_expired) begin
          state_d = S_FAULT;
        end
      end
      S_HOLD: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (instr_ready) begin
          state_d = S_IDLE;
          adv_d   = 1'b1;
        end
      end
      S_DRAIN: begin
        // The response is discarded. A timeout here is silent.
        tmr_en = 1'b1;
        if (imem_rvalid || tmr_expired) begin
          state_d = S_IDLE;
        end
      end
      S_FAULT: begin
        if (flush) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      out_q   <= XLEN'(NOP);
      pc_q    <= '0;
      adv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      out_q   <= out_d;
      pc_q    <= pc_d;
      adv_q   <= adv_d;
    end
  end

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = addr_q;
  assign instr_valid = (state_q == S_HOLD);
  assign instr_out   = out_q;
  assign instr_pc    = pc_q;
  assign instr_fault = (state_q == S_FAULT);
  assign pc_advance  = adv_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_risc_ifetch.sv
// Directed bench for risc_ifetch (TIMEOUT=4).
// Inputs change 1 ns after each rising edge. Outputs are checked at the
// same point.
module tb_risc_ifetch;
  import risc_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_en;
  logic [31:0]   pc_addr;
  logic          flush;
  logic          pc_advance;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [31:0]   imem_rdata;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr_out;
  logic [31:0]   instr_pc;
  logic          instr_fault;
  ifetch_state_t dbg_state;

  int checks   = 0;
  int failures = 0;

  // clock
  always #5 clk = ~clk;

  risc_ifetch #(
    .TIMEOUT (4),
    .XLEN    (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .pc_addr     (pc_addr),
    .flush       (flush),
    .pc_advance  (pc_advance),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_fault (instr_fault),
    .dbg_state   (dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_st(input string tag, input ifetch_state_t exp);
    check(tag, 32'(dbg_state), 32'(exp));
  endtask

  // Drive a fetch with immediate grant and response; ends in HOLD.
  task automatic fetch_to_hold(input logic [31:0] pc, input logic [31:0] data);
    fetch_en = 1'b1; pc_addr = pc;
    step();
    fetch_en = 1'b0; imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = data;
    step();
    imem_rvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; pc_addr = '0; flush = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset values
    check_st("rst_state", S_IDLE);
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_out",   instr_out, 32'h0000_0013);
    check("rst_pc",    instr_pc, 32'h0);
    check("rst_adv",   32'(pc_advance), 32'd0);
    check("rst_fault", 32'(instr_fault), 32'd0);

    // Basic fetch at 0x100, minimum latency
    fetch_en = 1'b1; pc_addr = 32'h100;
    step();
    check_st("f1_req_state", S_REQ);
    check("f1_req", 32'(imem_req), 32'd1);
    check("f1_addr", imem_addr, 32'h100);
    check("f1_valid0", 32'(instr_valid), 32'd0);
    fetch_en = 1'b0; imem_gnt = 1'b1;
    step();
    check_st("f1_wait_state", S_WAIT);
    check("f1_req_drop", 32'(imem_req), 32'd0);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    imem_rvalid = 1'b0; imem_rdata = 32'h1111_1111;
    check("f1_valid", 32'(instr_valid), 32'd1);
    check("f1_out", instr_out, 32'h0050_0093);
    check("f1_pc", instr_pc, 32'h100);

    // Stall in HOLD for 4 cycles, then accept
    for (int i = 0; i < 4; i++) begin
      step();
      check("hold_valid", 32'(instr_valid), 32'd1);
      check("hold_out", instr_out, 32'h0050_0093);
      check("hold_pc", instr_pc, 32'h100);
      check("hold_adv", 32'(pc_advance), 32'd0);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check_st("acc_state", S_IDLE);
    check("acc_adv", 32'(pc_advance), 32'd1);
    check("acc_valid", 32'(instr_valid), 32'd0);
    step();
    check("acc_adv_pulse", 32'(pc_advance), 32'd0);
    check_st("acc_idle", S_IDLE);

    // Timeout: grant given, no response for 4 WAIT cycles
    fetch_en = 1'b1; pc_addr = 32'h200;
    step();
    fetch_en = 1'b0; imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    check_st("to_wait0", S_WAIT);
    for (int i = 1; i < 4; i++) begin
      step();
      check_st("to_wait", S_WAIT);
      check("to_nofault", 32'(instr_fault), 32'd0);
    end
    step();
    check_st("to_fault_state", S_FAULT);
    check("to_fault", 32'(instr_fault), 32'd1);
    check("to_req", 32'(imem_req), 32'd0);
    check("to_valid", 32'(instr_valid), 32'd0);
    fetch_en = 1'b1; imem_rvalid = 1'b1;
    step();
    step();
    fetch_en = 1'b0; imem_rvalid = 1'b0;
    check("to_sticky", 32'(instr_fault), 32'd1);
    check("to_sticky_req", 32'(imem_req), 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_st("to_clear_state", S_IDLE);
    check("to_clear", 32'(instr_fault), 32'd0);

    // Flush in WAIT; late response 2 cycles later is discarded
    fetch_en = 1'b1; pc_addr = 32'h300;
    step();
    fetch_en = 1'b0; imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    check_st("fw_drain", S_DRAIN);
    step();
    check_st("fw_drain2", S_DRAIN);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    check_st("fw_idle", S_IDLE);
    check("fw_valid", 32'(instr_valid), 32'd0);
    check("fw_out_kept", instr_out, 32'h0050_0093);
    step();
    check("fw_valid2", 32'(instr_valid), 32'd0);

    // Flush and ready together in HOLD: no pc_advance
    fetch_to_hold(32'h400, 32'h00A0_0113);
    check("fr_valid", 32'(instr_valid), 32'd1);
    check("fr_out", instr_out, 32'h00A0_0113);
    flush = 1'b1; instr_ready = 1'b1;
    step();
    flush = 1'b0; instr_ready = 1'b0;
    check_st("fr_idle", S_IDLE);
    check("fr_adv", 32'(pc_advance), 32'd0);
    check("fr_valid0", 32'(instr_valid), 32'd0);
    step();
    check("fr_adv2", 32'(pc_advance), 32'd0);

    // Flush and grant together in REQ: DRAIN, then response ends it
    fetch_en = 1'b1; pc_addr = 32'h500;
    step();
    fetch_en = 1'b0; flush = 1'b1; imem_gnt = 1'b1;
    step();
    flush = 1'b0; imem_gnt = 1'b0;
    check_st("fg_drain", S_DRAIN);
    check("fg_req", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    imem_rvalid = 1'b0;
    check_st("fg_idle", S_IDLE);
    check("fg_valid", 32'(instr_valid), 32'd0);

    // DRAIN with no response times out to IDLE without fault
    fetch_en = 1'b1; pc_addr = 32'h540;
    step();
    fetch_en = 1'b0; flush = 1'b1; imem_gnt = 1'b1;
    step();
    flush = 1'b0; imem_gnt = 1'b0;
    for (int i = 1; i < 4; i++) begin
      step();
      check_st("dt_drain", S_DRAIN);
    end
    step();
    check_st("dt_idle", S_IDLE);
    check("dt_nofault", 32'(instr_fault), 32'd0);

    // Flush in REQ without grant
    fetch_en = 1'b1; pc_addr = 32'h600;
    step();
    fetch_en = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    check_st("fq_idle", S_IDLE);
    check("fq_req", 32'(imem_req), 32'd0);

    // fetch_en with flush in IDLE does not start
    fetch_en = 1'b1; flush = 1'b1; pc_addr = 32'h640;
    step();
    fetch_en = 1'b0; flush = 1'b0;
    check_st("fi_idle", S_IDLE);

    // Misaligned PC
    fetch_en = 1'b1; pc_addr = 32'h102;
    step();
    fetch_en = 1'b0;
`ifdef IFETCH_MISALIGN_CHK_EN
    check_st("ma_state", S_FAULT);
    check("ma_fault", 32'(instr_fault), 32'd1);
    check("ma_req", 32'(imem_req), 32'd0);
    check("ma_pc", instr_pc, 32'h102);
`else
    check_st("ma_state", S_REQ);
    check("ma_req", 32'(imem_req), 32'd1);
    check("ma_addr", imem_addr, 32'h100);
`endif
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_st("ma_idle", S_IDLE);

    // Reset during WAIT; a later response in IDLE is ignored
    fetch_en = 1'b1; pc_addr = 32'h700;
    step();
    fetch_en = 1'b0; imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0;
    check_st("rw_idle", S_IDLE);
    check("rw_addr", imem_addr, 32'h0);
    check("rw_out", instr_out, 32'h0000_0013);
    imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_F00D;
    step();
    imem_rvalid = 1'b0;
    check_st("rw_idle2", S_IDLE);
    check("rw_valid", 32'(instr_valid), 32'd0);
    check("rw_out2", instr_out, 32'h0000_0013);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/risc_ifetch.md
RISC_IFETCH -- requirements
Module: risc_ifetch

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the max cycles waited in WAIT for imem_rvalid after grant.
REQ-002 Parameter XLEN, default 32, SHALL set address/instruction width.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 fetch_en  in  1  permit starting a new fetch.
REQ-006 pc_addr  in  XLEN  current PC from the PC register.
REQ-007 flush  in  1  branch/redirect taken; abandon the current fetch.
REQ-008 pc_advance  out  1  one-cycle pulse telling the PC register to update.
REQ-009 imem_req / imem_addr  out  1 / XLEN  memory request and word address.
REQ-010 imem_gnt  in  1  memory accepted the request this cycle.
REQ-011 imem_rvalid / imem_rdata  in  1 / XLEN  read response valid and data.
REQ-012 instr_valid / instr_ready  out / in  1 / 1  decode-side handshake.
REQ-013 instr_out / instr_pc  out  XLEN / XLEN  fetched instruction and its address.
REQ-014 instr_fault  out  1  sticky fetch fault (timeout, or misalignment when enabled).

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT, HOLD, DRAIN, FAULT.
REQ-016 IDLE: fetch_en=1 and flush=0 -> REQ; pc_addr latched into imem_addr at that edge.
REQ-017 REQ: imem_req=1 with imem_addr held stable; imem_gnt=1 -> WAIT with timeout counter cleared to 0.
REQ-018 WAIT: each cycle without imem_rvalid, counter+1; counter==TIMEOUT-1 with no rvalid -> FAULT.
REQ-019 WAIT with imem_rvalid=1: instr_out<=imem_rdata, instr_pc<=imem_addr -> HOLD; instr_valid=1 from the next cycle.
REQ-020 HOLD: instr_valid=1 and instr_out/instr_pc stable until instr_ready=1; on that edge -> IDLE with pc_advance=1 for exactly the following cycle.
REQ-021 Minimum latency: IDLE to instr_valid=1 is 3 cycles with gnt in the first REQ cycle and rvalid in the first WAIT cycle.
REQ-022 flush in IDLE, HOLD, or REQ without gnt -> IDLE next cycle; imem_req, instr_valid, and pc_advance deasserted.
REQ-023 flush in REQ with imem_gnt=1 the same cycle -> DRAIN; the grant stands.
REQ-024 flush in WAIT without rvalid -> DRAIN; flush with rvalid the same cycle -> IDLE with data discarded.
REQ-025 DRAIN: discard imem_rdata; rvalid or counter==TIMEOUT-1 -> IDLE; no fault raised in DRAIN.
REQ-026 flush and instr_ready together in HOLD: flush wins; no pc_advance.
REQ-027 FAULT: instr_fault=1, imem_req=0, instr_valid=0; exit only by flush (-> IDLE, fault cleared) or rst.
REQ-028 The counter SHALL saturate and never wrap; with TIMEOUT=1, a missing rvalid in the first WAIT cycle -> FAULT.

Reset
REQ-029 On rst=1 at posedge: state=IDLE, counter=0, imem_req=0, imem_addr=0, instr_valid=0, instr_out=32'h0000_0013 (NOP), instr_pc=0, pc_advance=0, instr_fault=0.
REQ-030 rst SHALL override flush and all handshakes; reset during WAIT or DRAIN abandons the transaction, and later rvalids in IDLE are ignored.

Configuration
REQ-031 Macro IFETCH_MISALIGN_CHK_EN defined: in IDLE, fetch_en=1 with pc_addr[1:0]!=0 -> FAULT directly, no request issued, instr_pc<=pc_addr.
REQ-032 Macro IFETCH_MISALIGN_CHK_EN undefined: no check; imem_addr is driven with pc_addr[1:0] forced to 2'b00.

Structure
REQ-033 Shared package risc_pkg SHALL hold XLEN, the NOP constant 32'h0000_0013, and the ifetch_state_t enum.
REQ-034 Timeout counter SHALL be sub-module risc_ifetch_tmr (clear, enable, saturate, expired output); the rest stays flat.

Verification
REQ-035 rst, then fetch_en=1, pc_addr=0x100, gnt in the first REQ cycle, rvalid with rdata=0x00500093 the next cycle -> instr_valid 3 cycles after fetch_en, instr_out=0x00500093, instr_pc=0x100.
REQ-036 HOLD with instr_ready=0 for 4 cycles, then 1 -> outputs stable for all 4 cycles, single pc_advance pulse, back to IDLE.
REQ-037 TIMEOUT=4, grant given, rvalid never returned -> instr_fault=1 after 4 WAIT cycles; flush -> IDLE with fault cleared.
REQ-038 flush in WAIT, then rvalid rdata=0xDEADBEEF 2 cycles later -> data discarded, no instr_valid, return to IDLE.
REQ-039 flush and instr_ready together in HOLD -> no pc_advance; flush and gnt together in REQ -> DRAIN.
REQ-040 With IFETCH_MISALIGN_CHK_EN, pc_addr=0x102 -> imem_req never asserted, instr_fault=1, instr_pc=0x102; without it -> imem_addr=0x100.
